writeback_arbiter: RTL

Writeback stage sitting directly upstream of the 32x32 register file. Merges single-cycle ALU results and multi-cycle load results (valid/ready from the load/store unit) into the register file's single write port. Keeps a per-register load scoreboard and drives `stall` back to decode so that no instruction reads or overwrites a register with a load still in flight.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/wb_fifo.sv | 62 ++++++
 rtl/writeback_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and writeback types for the register-file write path
package cpu_pkg;

    localparam int word_width     = 32;
    localparam int reg_addr_width = 5;

    // Which source owns the register-file write port in the current cycle.
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LOAD
    } wb_src_e;

    typedef struct packed {
        logic [reg_addr_width-1:0] rd;
        logic [word_width-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback requests buffering load results
//
// Ports:
//   clk, reset        clock, synchronous active-low reset (empties the FIFO)
//   push, push_data   write one wb_req_t (caller guarantees !full)
//   pop, pop_data     pop_data is the head; pop advances it (caller guarantees !empty)
//   full, empty       occupancy flags
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int depth = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t pop_data,
    output logic    full,
    output logic    empty
);

    localparam int ptr_w = $clog2(depth);

    wb_req_t          mem [depth];
    logic [ptr_w-1:0] rd_ptr;
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w:0]   count;

    // Storage is not reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (ptr_w + 1)'(depth));
    assign empty    = (count == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU and load results onto the register-file write port
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   issue_valid/is_load/rd/rs1/rs2  instruction presented by decode
//   stall                           decode must hold the presented instruction
//   alu_valid/rd/data               single-cycle ALU result, never back-pressured
//   lsu_valid/ready/rd/data         load result handshake from the load/store unit
//   rf_wren/rf_wr_addr/rf_data_in   registered register-file write port
module writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int word_width     = 32,
    parameter int reg_addr_width = 5,
    parameter int lsu_fifo_depth = 2,
    parameter int max_loads      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic                      issue_is_load,
    input  logic [reg_addr_width-1:0] issue_rd,
    input  logic [reg_addr_width-1:0] issue_rs1,
    input  logic [reg_addr_width-1:0] issue_rs2,
    output logic                      stall,
    input  logic                      alu_valid,
    input  logic [reg_addr_width-1:0] alu_rd,
    input  logic [word_width-1:0]     alu_data,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [reg_addr_width-1:0] lsu_rd,
    input  logic [word_width-1:0]     lsu_data,
    output logic                      rf_wren,
    output logic [reg_addr_width-1:0] rf_wr_addr,
    output logic [word_width-1:0]     rf_data_in
);

    localparam int num_regs = 2 ** reg_addr_width;
    localparam int cnt_w    = $clog2(max_loads + 1);

    logic [num_regs-1:0] pending;
    logic [num_regs-1:0] pending_next;
    logic [cnt_w-1:0]    load_count;
    wb_src_e             wb_src;
    wb_src_e             wb_src_next;

    wb_req_t lsu_req;
    wb_req_t fifo_head;
    logic    fifo_push;
    logic    fifo_pop;
    logic    fifo_full;
    logic    fifo_empty;
    logic    alu_win;
    logic    load_issue;
    logic    load_retire;

    assign stall = issue_valid & (pending[issue_rs1] | pending[issue_rs2] | pending[issue_rd] |
                                  (issue_is_load & (load_count == cnt_w'(max_loads))));

    assign load_issue = issue_valid & issue_is_load & ~stall;

    // Held low during reset so the LSU cannot push into a FIFO being flushed.
    assign lsu_ready = reset & ~fifo_full;
    assign fifo_push = lsu_valid & lsu_ready;
    assign lsu_req   = '{rd: lsu_rd, data: lsu_data};

    wb_fifo #(
        .depth(lsu_fifo_depth)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(lsu_req),
        .pop      (fifo_pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ALU results cannot wait, so they always win; x0 writes are dropped and free the port.
    assign alu_win  = alu_valid & (alu_rd != '0);
    assign fifo_pop = ~alu_win & ~fifo_empty;

    always_comb begin
        wb_src_next = WB_NONE;
        if (alu_win) begin
            wb_src_next = WB_ALU;
        end else if (fifo_pop) begin
            wb_src_next = WB_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_src     <= WB_NONE;
            rf_wren    <= 1'b0;
            rf_wr_addr <= '0;
            rf_data_in <= '0;
        end else begin
            wb_src <= wb_src_next;
            case (wb_src_next)
                WB_ALU: begin
                    rf_wren    <= 1'b1;
                    rf_wr_addr <= alu_rd;
                    rf_data_in <= alu_data;
                end
                WB_LOAD: begin
                    rf_wren    <= (fifo_head.rd != '0);
                    rf_wr_addr <= fifo_head.rd;
                    rf_data_in <= fifo_head.data;
                end
                default: begin
                    rf_wren    <= 1'b0;
                    rf_wr_addr <= '0;
                    rf_data_in <= '0;
                end
            endcase
        end
    end

    // A load retires on the edge where the register file captures it, i.e. the
    // edge that ends the cycle in which the popped load sits on rf_*. An x0 load
    // still retires here so the outstanding count stays exact.
    assign load_retire = (wb_src == WB_LOAD);

    always_comb begin
        pending_next = pending;
        if (load_retire) begin
            pending_next[rf_wr_addr] = 1'b0;
        end
        if (load_issue) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending    <= '0;
            load_count <= '0;
        end else begin
            pending <= pending_next;
            case ({load_issue, load_retire})
                2'b10:   load_count <= load_count + 1'b1;
                2'b01:   load_count <= load_count - 1'b1;
                default: load_count <= load_count;
            endcase
        end
    end

endmodule
